asym_width_fifo: RTL and testbench

- Single-clock FIFO with independent write and read widths: the write side accepts WIDTHW-bit words and the read side delivers WIDTHR-bit words.
- Data is stored as minWIDTH-bit narrow units, packed little-endian. Supports both upsizing (narrow in, wide out) and downsizing (wide in, narrow out).
- Sits between byte-oriented producers and word-oriented consumers, or the reverse, in streaming datapaths.
- Adds handshake, occupancy tracking, full/empty flags and error flags on top of the asymmetric dual-port RAM style.

---
 rtl/asym_pkg.sv | 23 ++
 rtl/asym_fifo_ram.sv | 56 +++++
 rtl/asym_width_fifo.sv | 77 +++++++
 tb/tb_asym_width_fifo.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/asym_pkg.sv
// asym_pkg: constant helpers shared by the asymmetric-width FIFO and its RAM
package asym_pkg;
  function automatic int clog2(input int v);
    int r = 0;
    for (int n = 1; n < v; n = n * 2) r++;
    return r;
  endfunction
  function automatic int max_w(input int a, input int b);
    return a > b ? a : b;
  endfunction
  function automatic int min_w(input int a, input int b);
    return a < b ? a : b;
  endfunction
  function automatic int ratio(input int w, input int r);
    return max_w(w, r) / min_w(w, r);
  endfunction
  function automatic int wr_units(input int w, input int r);
    return w / min_w(w, r);
  endfunction
  function automatic int rd_units(input int w, input int r);
    return r / min_w(w, r);
  endfunction
endpackage

// File: rtl/asym_fifo_ram.sv
// asym_fifo_ram: narrow-unit RAM split into RATIO lanes, WIDTHW write port and registered WIDTHR read port
module asym_fifo_ram
  import asym_pkg::*;
#(
  parameter int WIDTHW    = 8,
  parameter int WIDTHR    = 32,
  parameter int DEPTH     = 256,
  parameter int ADDRWIDTH = 8
) (
  input  logic                 clk,
  input  logic                 i_we,
  input  logic [ADDRWIDTH-1:0] i_waddr,
  input  logic [WIDTHW-1:0]    i_wdata,
  input  logic                 i_re,
  input  logic [ADDRWIDTH-1:0] i_raddr,
  output logic [WIDTHR-1:0]    o_rdata
);
  localparam int MINW  = min_w(WIDTHW, WIDTHR);
  localparam int RATIO = ratio(WIDTHW, WIDTHR);
  localparam int WRU   = wr_units(WIDTHW, WIDTHR);
  localparam int RDU   = rd_units(WIDTHW, WIDTHR);
  localparam int LW    = clog2(RATIO);
  localparam int RW    = ADDRWIDTH - LW;
  localparam int ROWS  = DEPTH / RATIO;
  logic [RATIO-1:0]      w_we;
  logic [RATIO*MINW-1:0] w_wd;
  logic [RATIO*MINW-1:0] w_q;
  logic [RW-1:0]         w_wrow;
  logic [RW-1:0]         w_rrow;
  // narrow unit address a lives in lane a%RATIO, row a/RATIO
  assign w_wrow = RW'(i_waddr >> LW);
  assign w_rrow = RW'(i_raddr >> LW);
  if (WRU == RATIO) begin : g_ww
    assign w_we = {RATIO{i_we}};
    assign w_wd = i_wdata;
  end else begin : g_wn
    assign w_we = i_we ? RATIO'(1) << i_waddr[LW-1:0] : '0;
    assign w_wd = {RATIO{i_wdata}};
  end
  for (genvar l = 0; l < RATIO; l++) begin : g_lane
    logic [MINW-1:0] r_mem [ROWS];
    logic [MINW-1:0] r_q;
    always_ff @(posedge clk) begin
      if (w_we[l]) r_mem[w_wrow] <= w_wd[l*MINW +: MINW];
      if (i_re) r_q <= r_mem[w_rrow];
    end
    assign w_q[l*MINW +: MINW] = r_q;
  end
  if (RDU == RATIO) begin : g_rw
    assign o_rdata = w_q;
  end else begin : g_rn
    logic [LW-1:0] r_rsel;
    always_ff @(posedge clk) if (i_re) r_rsel <= i_raddr[LW-1:0];
    assign o_rdata = w_q[r_rsel*MINW +: MINW];
  end
endmodule

// File: rtl/asym_width_fifo.sv
// asym_width_fifo: single-clock FIFO with independent write/read widths, level-based flags
module asym_width_fifo
  import asym_pkg::*;
#(
  parameter int WIDTHW    = 8,
  parameter int WIDTHR    = 32,
  parameter int DEPTH     = 256,
  parameter int ADDRWIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [WIDTHW-1:0]    wr_data,
  output logic                 full,
  input  logic                 rd_en,
  output logic [WIDTHR-1:0]    rd_data,
  output logic                 rd_valid,
  output logic                 empty,
  output logic [ADDRWIDTH:0]   level,
  output logic                 overflow,
  output logic                 underflow
);
  localparam int WRU = wr_units(WIDTHW, WIDTHR);
  localparam int RDU = rd_units(WIDTHW, WIDTHR);
  logic                 w_wr_acc, w_rd_acc;
  logic [ADDRWIDTH:0]   w_level_next;
  logic [WIDTHR-1:0]    w_ram_q;
  logic [ADDRWIDTH-1:0] r_wr_ptr, r_rd_ptr;
  logic [ADDRWIDTH:0]   r_level;
  logic                 r_full, r_empty, r_rd_valid, r_ovf, r_udf, r_loaded;
  assign w_wr_acc     = wr_en && !r_full;
  assign w_rd_acc     = rd_en && !r_empty;
  assign w_level_next = r_level + (w_wr_acc ? (ADDRWIDTH+1)'(WRU) : '0)
                                - (w_rd_acc ? (ADDRWIDTH+1)'(RDU) : '0);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_full     <= 1'b0;
      r_empty    <= 1'b1;
      r_rd_valid <= 1'b0;
      r_ovf      <= 1'b0;
      r_udf      <= 1'b0;
      r_loaded   <= 1'b0;
    end else begin
      r_wr_ptr   <= w_wr_acc ? r_wr_ptr + ADDRWIDTH'(WRU) : r_wr_ptr;
      r_rd_ptr   <= w_rd_acc ? r_rd_ptr + ADDRWIDTH'(RDU) : r_rd_ptr;
      r_level    <= w_level_next;
      r_full     <= w_level_next > (ADDRWIDTH+1)'(DEPTH - WRU);
      r_empty    <= w_level_next < (ADDRWIDTH+1)'(RDU);
      r_rd_valid <= w_rd_acc;
      r_ovf      <= wr_en && r_full;
      r_udf      <= rd_en && r_empty;
      r_loaded   <= r_loaded || w_rd_acc;
    end
  end
  asym_fifo_ram #(
    .WIDTHW(WIDTHW), .WIDTHR(WIDTHR), .DEPTH(DEPTH), .ADDRWIDTH(ADDRWIDTH)
  ) u_ram (
    .clk(clk),
    .i_we(w_wr_acc),
    .i_waddr(r_wr_ptr),
    .i_wdata(wr_data),
    .i_re(w_rd_acc),
    .i_raddr(r_rd_ptr),
    .o_rdata(w_ram_q)
  );
  // RAM output is not resettable, so rd_data reads zero until the first pop after reset
  assign rd_data   = r_loaded ? w_ram_q : '0;
  assign full      = r_full;
  assign empty     = r_empty;
  assign level     = r_level;
  assign rd_valid  = r_rd_valid;
  assign overflow  = r_ovf;
  assign underflow = r_udf;
endmodule

// File: tb/tb_asym_width_fifo.sv
// tb_asym_width_fifo: directed and scoreboarded checks on an upsizing (8->32) and a downsizing (32->8) instance
module tb_asym_width_fifo;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic        a_wr_en = 1'b0, a_rd_en = 1'b0;
  logic [7:0]  a_wr_data = '0;
  logic [31:0] a_rd_data;
  logic        a_full, a_empty, a_rd_valid, a_ovf, a_udf;
  logic [8:0]  a_level;
  logic        b_wr_en = 1'b0, b_rd_en = 1'b0;
  logic [31:0] b_wr_data = '0;
  logic [7:0]  b_rd_data;
  logic        b_full, b_empty, b_rd_valid, b_ovf, b_udf;
  logic [6:0]  b_level;
  int n_tests = 0;
  int n_fail = 0;

  asym_width_fifo #(.WIDTHW(8), .WIDTHR(32), .DEPTH(256), .ADDRWIDTH(8)) u_up (
    .clk(clk), .rst(rst), .wr_en(a_wr_en), .wr_data(a_wr_data), .full(a_full),
    .rd_en(a_rd_en), .rd_data(a_rd_data), .rd_valid(a_rd_valid), .empty(a_empty),
    .level(a_level), .overflow(a_ovf), .underflow(a_udf));

  asym_width_fifo #(.WIDTHW(32), .WIDTHR(8), .DEPTH(64), .ADDRWIDTH(6)) u_dn (
    .clk(clk), .rst(rst), .wr_en(b_wr_en), .wr_data(b_wr_data), .full(b_full),
    .rd_en(b_rd_en), .rd_data(b_rd_data), .rd_valid(b_rd_valid), .empty(b_empty),
    .level(b_level), .overflow(b_ovf), .underflow(b_udf));

  task automatic a_op(input logic we, input logic [7:0] wd, input logic re);
    a_wr_en = we; a_wr_data = wd; a_rd_en = re;
    @(posedge clk); #1;
    a_wr_en = 1'b0; a_rd_en = 1'b0;
  endtask

  task automatic b_op(input logic we, input logic [31:0] wd, input logic re);
    b_wr_en = we; b_wr_data = wd; b_rd_en = re;
    @(posedge clk); #1;
    b_wr_en = 1'b0; b_rd_en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_tests++; if (a_empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty got %b want 1", a_empty); end
    n_tests++; if (a_full !== 1'b0) begin n_fail++; $display("FAIL reset_full got %b want 0", a_full); end
    n_tests++; if (a_level !== 9'd0) begin n_fail++; $display("FAIL reset_level got %0d want 0", a_level); end
    n_tests++; if (a_rd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rd_valid got %b want 0", a_rd_valid); end
    n_tests++; if (a_rd_data !== 32'h0) begin n_fail++; $display("FAIL reset_rd_data got %h want 0", a_rd_data); end
    n_tests++; if (b_empty !== 1'b1 || b_level !== 7'd0) begin n_fail++; $display("FAIL reset_b got empty=%b level=%0d want 1/0", b_empty, b_level); end
    rst = 1'b0;
  endtask

  task automatic test_upsize();
    a_op(1, 8'h11, 0); a_op(1, 8'h22, 0); a_op(1, 8'h33, 0);
    n_tests++; if (a_level !== 9'd3 || a_empty !== 1'b1) begin n_fail++; $display("FAIL upsize_partial got level=%0d empty=%b want 3/1", a_level, a_empty); end
    a_op(1, 8'h44, 0);
    n_tests++; if (a_level !== 9'd4 || a_empty !== 1'b0) begin n_fail++; $display("FAIL upsize_word got level=%0d empty=%b want 4/0", a_level, a_empty); end
    a_op(0, 8'h00, 1);
    n_tests++; if (a_rd_data !== 32'h44332211) begin n_fail++; $display("FAIL upsize_data got %h want 44332211", a_rd_data); end
    n_tests++; if (a_rd_valid !== 1'b1) begin n_fail++; $display("FAIL upsize_valid got %b want 1", a_rd_valid); end
    n_tests++; if (a_level !== 9'd0 || a_empty !== 1'b1) begin n_fail++; $display("FAIL upsize_drained got level=%0d empty=%b want 0/1", a_level, a_empty); end
    a_op(0, 8'h00, 0);
    n_tests++; if (a_rd_valid !== 1'b0 || a_rd_data !== 32'h44332211) begin n_fail++; $display("FAIL upsize_hold got valid=%b data=%h want 0/44332211", a_rd_valid, a_rd_data); end
  endtask

  task automatic test_full_overflow();
    for (int i = 0; i < 256; i++) a_op(1, 8'(i), 0);
    n_tests++; if (a_full !== 1'b1 || a_level !== 9'd256) begin n_fail++; $display("FAIL full_set got full=%b level=%0d want 1/256", a_full, a_level); end
    a_op(1, 8'h99, 0);
    n_tests++; if (a_ovf !== 1'b1 || a_level !== 9'd256) begin n_fail++; $display("FAIL overflow_pulse got ovf=%b level=%0d want 1/256", a_ovf, a_level); end
    a_op(0, 8'h00, 0);
    n_tests++; if (a_ovf !== 1'b0) begin n_fail++; $display("FAIL overflow_clear got %b want 0", a_ovf); end
    a_op(0, 8'h00, 1);
    n_tests++; if (a_level !== 9'd252 || a_full !== 1'b0) begin n_fail++; $display("FAIL full_release got level=%0d full=%b want 252/0", a_level, a_full); end
    n_tests++; if (a_rd_data !== 32'h03020100) begin n_fail++; $display("FAIL full_first_word got %h want 03020100", a_rd_data); end
    repeat (63) a_op(0, 8'h00, 1);
    n_tests++; if (a_level !== 9'd0 || a_empty !== 1'b1 || a_rd_data !== 32'hFFFEFDFC) begin n_fail++; $display("FAIL full_drain got level=%0d empty=%b data=%h want 0/1/fffefdfc", a_level, a_empty, a_rd_data); end
  endtask

  task automatic test_underflow_simul();
    a_op(0, 8'h00, 1);
    n_tests++; if (a_udf !== 1'b1 || a_rd_valid !== 1'b0) begin n_fail++; $display("FAIL underflow_pulse got udf=%b valid=%b want 1/0", a_udf, a_rd_valid); end
    n_tests++; if (a_rd_data !== 32'hFFFEFDFC) begin n_fail++; $display("FAIL underflow_hold got %h want fffefdfc", a_rd_data); end
    a_op(0, 8'h00, 0);
    n_tests++; if (a_udf !== 1'b0) begin n_fail++; $display("FAIL underflow_clear got %b want 0", a_udf); end
    a_op(1, 8'hAA, 0); a_op(1, 8'hBB, 0); a_op(1, 8'hCC, 0); a_op(1, 8'hDD, 0);
    a_op(1, 8'hEE, 1);
    n_tests++; if (a_level !== 9'd1 || a_empty !== 1'b1) begin n_fail++; $display("FAIL simul_level got level=%0d empty=%b want 1/1", a_level, a_empty); end
    n_tests++; if (a_rd_data !== 32'hDDCCBBAA || a_rd_valid !== 1'b1) begin n_fail++; $display("FAIL simul_data got %h valid=%b want ddccbbaa/1", a_rd_data, a_rd_valid); end
  endtask

  task automatic test_downsize();
    logic [31:0] w = 32'hA1B2C3D4;
    b_op(1, w, 0);
    n_tests++; if (b_level !== 7'd4 || b_empty !== 1'b0) begin n_fail++; $display("FAIL down_level got level=%0d empty=%b want 4/0", b_level, b_empty); end
    for (int k = 0; k < 4; k++) begin
      b_op(0, 32'h0, 1);
      n_tests++; if (b_rd_data !== w[k*8 +: 8] || b_rd_valid !== 1'b1) begin n_fail++; $display("FAIL down_byte%0d got %h valid=%b want %h/1", k, b_rd_data, b_rd_valid, w[k*8 +: 8]); end
    end
    n_tests++; if (b_level !== 7'd0 || b_empty !== 1'b1) begin n_fail++; $display("FAIL down_drained got level=%0d empty=%b want 0/1", b_level, b_empty); end
  endtask

  task automatic test_random_stream();
    logic [7:0]  q[$];
    logic [7:0]  exp_b;
    logic [31:0] w;
    logic        we, re, wacc, racc;
    int lvl = 0, sent = 0, cyc = 0, prev;
    while (!(sent == 1000 && lvl == 0) && cyc < 20000) begin
      we = sent < 1000 && $urandom_range(0, 99) < 30;
      re = $urandom_range(0, 99) < 85;
      w = $urandom;
      wacc = we && lvl <= 60;
      racc = re && lvl >= 1;
      prev = lvl;
      b_op(we, w, re);
      cyc++;
      if (racc) exp_b = q.pop_front();
      if (wacc) begin
        for (int k = 0; k < 4; k++) q.push_back(w[k*8 +: 8]);
        sent++;
      end
      lvl = lvl + (wacc ? 4 : 0) - (racc ? 1 : 0);
      n_tests++; if (b_level !== 7'(lvl)) begin n_fail++; $display("FAIL stream_level cyc %0d got %0d want %0d", cyc, b_level, lvl); end
      n_tests++; if (b_rd_valid !== racc) begin n_fail++; $display("FAIL stream_valid cyc %0d got %b want %b", cyc, b_rd_valid, racc); end
      if (racc) begin
        n_tests++; if (b_rd_data !== exp_b) begin n_fail++; $display("FAIL stream_data cyc %0d got %h want %h", cyc, b_rd_data, exp_b); end
      end
      n_tests++; if (b_full !== (lvl > 60) || b_empty !== (lvl == 0)) begin n_fail++; $display("FAIL stream_flags cyc %0d got full=%b empty=%b level %0d", cyc, b_full, b_empty, lvl); end
      n_tests++; if (b_ovf !== (we && prev > 60) || b_udf !== (re && prev == 0)) begin n_fail++; $display("FAIL stream_errflags cyc %0d got ovf=%b udf=%b", cyc, b_ovf, b_udf); end
    end
    n_tests++; if (cyc >= 20000) begin n_fail++; $display("FAIL stream_timeout got sent=%0d level=%0d want 1000/0", sent, lvl); end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 36; i++) a_op(1, 8'(i + 1), 0);
    n_tests++; if (a_level !== 9'd37) begin n_fail++; $display("FAIL areset_pre_level got %0d want 37", a_level); end
    #1 rst = 1'b1;
    #1;
    n_tests++; if (a_level !== 9'd0 || a_empty !== 1'b1 || a_full !== 1'b0) begin n_fail++; $display("FAIL areset_flags got level=%0d empty=%b full=%b want 0/1/0", a_level, a_empty, a_full); end
    n_tests++; if (a_rd_data !== 32'h0 || a_rd_valid !== 1'b0) begin n_fail++; $display("FAIL areset_data got %h valid=%b want 0/0", a_rd_data, a_rd_valid); end
    #1 rst = 1'b0;
    a_op(1, 8'h05, 0); a_op(1, 8'h06, 0); a_op(1, 8'h07, 0); a_op(1, 8'h08, 0);
    n_tests++; if (a_level !== 9'd4 || a_empty !== 1'b0) begin n_fail++; $display("FAIL areset_refill got level=%0d empty=%b want 4/0", a_level, a_empty); end
    a_op(0, 8'h00, 1);
    n_tests++; if (a_rd_data !== 32'h08070605 || a_level !== 9'd0) begin n_fail++; $display("FAIL areset_read got %h level=%0d want 08070605/0", a_rd_data, a_level); end
  endtask

  initial begin
    test_reset();
    test_upsize();
    test_full_overflow();
    test_underflow_simul();
    test_downsize();
    test_random_stream();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
